// File: rtl/dp_pkg.sv
// Shared helpers for the multiplier-sharing datapath blocks.
package dp_pkg;

  // Largest requester count the arbiter is sized for.
  localparam int DP_MAX_REQ = 16;

  // Ceiling log2, used to size requester-index fields.
  function automatic int clog2(input int n);
    int r;
    r = 0;
    for (int i = 0; i < 32; i++) begin
      if ((1 << i) < n) r = i + 1;
    end
    return r;
  endfunction

  // Low bit of lane idx inside a packed vector of width-bit lanes.
  function automatic int slice_lo(input int idx, input int width);
    return idx * width;
  endfunction

endpackage

// File: rtl/dp_mul_arbiter_rr_arbiter.sv
// Combinational round-robin picker: first set request after ptr, wrapping.
module rr_arbiter
  import dp_pkg::*;
#(
  parameter int NREQ = 4,
  parameter int IDW  = clog2(NREQ)
) (
  input  logic [NREQ-1:0] req,
  input  logic [IDW-1:0]  ptr,
  input  logic            en,
  output logic [NREQ-1:0] gnt,
  output logic [IDW-1:0]  gnt_idx
);

  logic           found;
  logic [IDW-1:0] idx;

  // Scan ptr+1 .. ptr+NREQ (mod NREQ) and grant the first requester seen.
  always_comb begin
    // NOTE: every output gets a default before the loop so no path leaves
    // a value unassigned, which would otherwise infer a latch.
    gnt     = '0;
    gnt_idx = '0;
    found   = 1'b0;
    idx     = '0;
    for (int k = 1; k <= NREQ; k++) begin
      idx = IDW'((int'(ptr) + k) % NREQ);
      if (en && !found && req[idx]) begin
        gnt[idx] = 1'b1;
        gnt_idx  = idx;
        found    = 1'b1;
      end
    end
  end

endmodule

// File: rtl/dp_mul_arbiter.sv
// Shares one pipelined multiplier among NREQ requesters; products return
// in acceptance order on one tagged response port.
module dp_mul_arbiter
  import dp_pkg::*;
#(
  parameter int DATAWIDTH = 8,
  parameter int NREQ      = 4,
  parameter int LATENCY   = 2,
  parameter int IDW       = 2
) (
  input  logic                      Clk,
  input  logic                      Rst,
  input  logic [NREQ-1:0]           req_valid,
  output logic [NREQ-1:0]           req_ready,
  input  logic [NREQ*DATAWIDTH-1:0] req_a,
  input  logic [NREQ*DATAWIDTH-1:0] req_b,
  output logic                      rsp_valid,
  input  logic                      rsp_ready,
  output logic [IDW-1:0]            rsp_id,
  output logic [2*DATAWIDTH-1:0]    rsp_data,
  output logic                      busy
);

  localparam int PW = 2 * DATAWIDTH;

  logic [LATENCY-1:0]   valid_q, valid_d;
  logic [IDW-1:0]       id_q   [LATENCY];
  logic [IDW-1:0]       id_d   [LATENCY];
  logic [PW-1:0]        data_q [LATENCY];
  logic [PW-1:0]        data_d [LATENCY];
  logic [IDW-1:0]       ptr_q, ptr_d;

  logic                 advance;
  logic                 accept;
  logic [NREQ-1:0]      gnt;
  logic [IDW-1:0]       gnt_idx;
  logic [DATAWIDTH-1:0] a_sel, b_sel;
  logic [PW-1:0]        product;

  // The whole pipeline moves only when the output slot is empty or being drained.
  assign advance = !valid_q[LATENCY-1] | rsp_ready;

  rr_arbiter #(
    .NREQ (NREQ),
    .IDW  (IDW)
  ) u_arb (
    .req     (req_valid),
    .ptr     (ptr_q),
    .en      (advance),
    .gnt     (gnt),
    .gnt_idx (gnt_idx)
  );

  assign req_ready = gnt;
  assign accept    = |(req_valid & gnt);

  // Route the granted requester's operands into the shared multiplier.
  always_comb begin
    a_sel = '0;
    b_sel = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (gnt_idx == IDW'(i)) begin
        a_sel = req_a[slice_lo(i, DATAWIDTH) +: DATAWIDTH];
        b_sel = req_b[slice_lo(i, DATAWIDTH) +: DATAWIDTH];
      end
    end
  end

  assign product = PW'(a_sel) * PW'(b_sel);

  // Next-state of the pipeline and round-robin pointer: shift on advance, hold otherwise.
  always_comb begin
    valid_d = valid_q;
    id_d    = id_q;
    data_d  = data_q;
    ptr_d   = ptr_q;
    if (advance) begin
      valid_d[0] = accept;
      id_d[0]    = gnt_idx;
      data_d[0]  = product;
      for (int s = 1; s < LATENCY; s++) begin
        valid_d[s] = valid_q[s-1];
        id_d[s]    = id_q[s-1];
        data_d[s]  = data_q[s-1];
      end
      if (accept) ptr_d = gnt_idx;
    end
  end

  // Pipeline and pointer registers; reset discards anything in flight.
  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      valid_q <= '0;
      ptr_q   <= IDW'(NREQ - 1);
      // NOTE: the payload stages are reset as well because rsp_id/rsp_data
      // must read zero out of reset; a plain storage array would not be.
      for (int s = 0; s < LATENCY; s++) begin
        id_q[s]   <= '0;
        data_q[s] <= '0;
      end
    end else begin
      // NOTE: non-blocking assignments so every stage samples the previous
      // stage's pre-edge value and the shift behaves as a true pipeline.
      valid_q <= valid_d;
      id_q    <= id_d;
      data_q  <= data_d;
      ptr_q   <= ptr_d;
    end
  end

  assign rsp_valid = valid_q[LATENCY-1];
  assign rsp_id    = id_q[LATENCY-1];
  assign rsp_data  = data_q[LATENCY-1];
  assign busy      = |valid_q;

endmodule

// File: tb/tb_dp_mul_arbiter.sv
// Scoreboard bench for dp_mul_arbiter: randomized and directed requests,
// expected products queued at acceptance, checked in order at the output.
module tb_dp_mul_arbiter;

  localparam int DW  = 8;
  localparam int N   = 4;
  localparam int L   = 2;
  localparam int IDW = 2;

  logic              Clk;
  logic              Rst;
  logic [N-1:0]      req_valid;
  logic [N-1:0]      req_ready;
  logic [N*DW-1:0]   req_a;
  logic [N*DW-1:0]   req_b;
  logic              rsp_valid;
  logic              rsp_ready;
  logic [IDW-1:0]    rsp_id;
  logic [2*DW-1:0]   rsp_data;
  logic              busy;

  dp_mul_arbiter #(
    .DATAWIDTH (DW),
    .NREQ      (N),
    .LATENCY   (L),
    .IDW       (IDW)
  ) dut (
    .Clk       (Clk),
    .Rst       (Rst),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_a     (req_a),
    .req_b     (req_b),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_id    (rsp_id),
    .rsp_data  (rsp_data),
    .busy      (busy)
  );

  typedef struct {
    int id;
    int data;
    int acc_cyc;
    int acc_stalls;
  } exp_t;

  exp_t         sb[$];
  int           checks;
  int           failures;
  int           cyc;
  int           stalls;
  int           model_ptr;
  bit           front_seen;
  logic [N-1:0] accepted_mask;
  logic [7:0]   a_v [N];
  logic [7:0]   b_v [N];
  int           rate;
  bit           rand_rdy;

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference rule: first requester after the last granted one, wrapping.
  function automatic int rr_pick(input logic [N-1:0] v, input int last);
    for (int k = 1; k <= N; k++) begin
      if (v[(last + k) % N]) return (last + k) % N;
    end
    return -1;
  endfunction

  // Output monitor: compare the front of the scoreboard whenever a product is shown.
  always @(negedge Clk) begin
    cyc++;
    if (!Rst) begin
      check("reset_rsp_valid", {31'd0, rsp_valid}, 32'd0);
      check("reset_busy", {31'd0, busy}, 32'd0);
      check("reset_rsp_id", {30'd0, rsp_id}, 32'd0);
      check("reset_rsp_data", {16'd0, rsp_data}, 32'd0);
      sb.delete();
      front_seen = 1'b0;
    end else begin
      check("busy", {31'd0, busy}, {31'd0, sb.size() != 0});
      if (rsp_valid) begin
        if (sb.size() == 0) begin
          check("unexpected_rsp", {31'd0, rsp_valid}, 32'd0);
        end else begin
          check("rsp_id", {30'd0, rsp_id}, sb[0].id);
          check("rsp_data", {16'd0, rsp_data}, sb[0].data);
          if (!front_seen) begin
            check("latency", cyc, sb[0].acc_cyc + L + (stalls - sb[0].acc_stalls));
            front_seen = 1'b1;
          end
          if (rsp_ready) begin
            void'(sb.pop_front());
            front_seen = 1'b0;
          end
        end
        if (!rsp_ready) stalls++;
      end
    end
  end

  // Request-side checker: grant vector against the round-robin rule; queue expectations.
  always @(negedge Clk) begin
    int           pick;
    logic [N-1:0] exp_gnt;
    exp_t         e;
    #1;
    if (!Rst) begin
      model_ptr     = N - 1;
      accepted_mask = '0;
    end else begin
      pick    = (!rsp_valid || rsp_ready) ? rr_pick(req_valid, model_ptr) : -1;
      exp_gnt = (pick >= 0) ? N'(1 << pick) : '0;
      check("req_ready", {28'd0, req_ready}, {28'd0, exp_gnt});
      accepted_mask = req_valid & req_ready;
      for (int i = 0; i < N; i++) begin
        if (accepted_mask[i]) begin
          e.id         = i;
          e.data       = int'(a_v[i]) * int'(b_v[i]);
          e.acc_cyc    = cyc;
          e.acc_stalls = stalls;
          sb.push_back(e);
          model_ptr    = i;
        end
      end
    end
  end

  task automatic issue(input int i, input logic [7:0] a, input logic [7:0] b);
    a_v[i]            = a;
    b_v[i]            = b;
    req_a[i*DW +: DW] = a;
    req_b[i*DW +: DW] = b;
    req_valid[i]      = 1'b1;
  endtask

  // One clock: retire accepted requests, optionally raise new ones, drive rsp_ready.
  task automatic step();
    @(posedge Clk);
    #1;
    for (int i = 0; i < N; i++) begin
      if (accepted_mask[i]) req_valid[i] = 1'b0;
    end
    for (int i = 0; i < N; i++) begin
      if (!req_valid[i] && rate > 0 && $urandom_range(99) < rate)
        issue(i, 8'($urandom), 8'($urandom));
    end
    if (rand_rdy) rsp_ready = ($urandom_range(3) != 0);
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((sb.size() != 0 || req_valid != '0) && n < 200) begin
      step();
      n++;
    end
    check("drain_timeout", {31'd0, n >= 200}, 32'd0);
    step();
    step();
  endtask

  initial begin
    checks    = 0;
    failures  = 0;
    cyc       = 0;
    stalls    = 0;
    model_ptr = N - 1;
    rate      = 0;
    rand_rdy  = 1'b0;
    accepted_mask = '0;
    front_seen = 1'b0;
    Rst       = 1'b0;
    req_valid = '0;
    req_a     = '0;
    req_b     = '0;
    rsp_ready = 1'b1;

    // Reset with every requester pending; first grant after release must be id 0.
    for (int i = 0; i < N; i++) issue(i, 8'(i + 3), 8'(i + 5));
    repeat (3) step();
    Rst = 1'b1;
    drain();

    // Single request, fixed latency.
    issue(2, 8'd12, 8'd13);
    drain();

    // All requesters streaming: strict 0,1,2,3 rotation, back-to-back responses.
    rate = 100;
    repeat (8) step();
    rate = 0;
    drain();

    // Backpressure: output stalled for 3 cycles while requests keep coming.
    rate = 100;
    repeat (4) step();
    rsp_ready = 1'b0;
    repeat (3) step();
    check("stall_req_ready", {28'd0, req_ready}, 32'd0);
    rsp_ready = 1'b1;
    rate = 0;
    drain();

    // Operand extremes.
    issue(1, 8'hFF, 8'hFF);
    issue(3, 8'h00, 8'hA5);
    issue(0, 8'hFF, 8'h00);
    drain();

    // Reset while products are in flight.
    rate = 100;
    repeat (3) step();
    check("midreset_pre_valid", {31'd0, rsp_valid}, 32'd1);
    Rst = 1'b0;
    #1;
    check("midreset_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    check("midreset_busy", {31'd0, busy}, 32'd0);
    rate = 0;
    req_valid = '0;
    repeat (2) step();
    Rst = 1'b1;
    issue(3, 8'd7, 8'd9);
    issue(0, 8'd2, 8'd200);
    drain();

    // Randomized traffic with random backpressure.
    rand_rdy = 1'b1;
    rate     = 40;
    repeat (400) step();
    rand_rdy  = 1'b0;
    rsp_ready = 1'b1;
    rate      = 0;
    drain();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
